// File: rtl/rr_prio_arbiter_pkg.sv
// rr_prio_arbiter_pkg: shared width helper for the arbiter and its priority encoder.
package rr_prio_arbiter_pkg;
    function automatic int enc_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_prio_arbiter_prio_encoder.sv
// rr_prio_arbiter_prio_encoder: picks the lowest or highest set bit of vec as index and one-hot.
module rr_prio_arbiter_prio_encoder
    import rr_prio_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit LSB_HIGH_PRIORITY = 1'b0,
    localparam int W = enc_width(WIDTH)
)(
    input  logic [WIDTH-1:0] vec,
    output logic             valid,
    output logic [W-1:0]     index,
    output logic [WIDTH-1:0] onehot
);
    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LSB_HIGH_PRIORITY) begin
                if (vec[WIDTH-1-i]) index = W'(WIDTH-1-i);
            end else begin
                if (vec[i]) index = W'(i);
            end
        end
    end

    assign valid  = |vec;
    assign onehot = valid ? (WIDTH'(1) << index) : '0;
endmodule

// File: rtl/rr_prio_arbiter.sv
// rr_prio_arbiter: N-way fixed-priority / round-robin arbiter with optional grant blocking.
// All outputs registered; one cycle from request to grant.
module rr_prio_arbiter
    import rr_prio_arbiter_pkg::*;
#(
    parameter int PORTS = 4,
    parameter bit ARB_TYPE_ROUND_ROBIN = 1'b0,
    parameter bit ARB_BLOCK = 1'b0,
    parameter bit ARB_BLOCK_ACK = 1'b1,
    parameter bit ARB_LSB_HIGH_PRIORITY = 1'b0,
    localparam int W = enc_width(PORTS)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] acknowledge,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [W-1:0]     grant_encoded
);
    logic [PORTS-1:0] mask, next_mask, next_grant, req_onehot, msk_onehot;
    logic [W-1:0]     next_encoded, req_index, msk_index, win_index;
    logic             next_valid, req_valid, msk_valid, use_masked, hold;

    rr_prio_arbiter_prio_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(ARB_LSB_HIGH_PRIORITY)) u_req_enc (
        .vec(request), .valid(req_valid), .index(req_index), .onehot(req_onehot)
    );

    rr_prio_arbiter_prio_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(ARB_LSB_HIGH_PRIORITY)) u_msk_enc (
        .vec(request & mask), .valid(msk_valid), .index(msk_index), .onehot(msk_onehot)
    );

    always_comb begin
        next_grant   = grant;
        next_valid   = grant_valid;
        next_encoded = grant_encoded;
        next_mask    = mask;
        use_masked   = ARB_TYPE_ROUND_ROBIN && msk_valid;
        win_index    = use_masked ? msk_index : req_index;
        hold         = ARB_BLOCK && (ARB_BLOCK_ACK ? grant_valid && (grant & acknowledge) == '0
                                                   : (grant & request) != '0);
        if (!hold) begin
            next_grant   = use_masked ? msk_onehot : req_onehot;
            next_valid   = req_valid;
            next_encoded = win_index;
            // mask keeps only the ports that come after the winner in rotation order
            if (ARB_TYPE_ROUND_ROBIN && req_valid)
                next_mask = ARB_LSB_HIGH_PRIORITY ? {PORTS{1'b1}} << (int'(win_index) + 1)
                                                  : {PORTS{1'b1}} >> (PORTS - int'(win_index));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
            mask          <= '0;
        end else begin
            grant         <= next_grant;
            grant_valid   <= next_valid;
            grant_encoded <= next_encoded;
            mask          <= next_mask;
        end
    end
endmodule

// File: tb/tb_rr_prio_arbiter.sv
// tb_rr_prio_arbiter: five arbiter configurations sharing one stimulus, checked by directed
// scenarios and a randomized run against a search-based reference model.
module tb_rr_prio_arbiter;
    localparam int N = 5;
    // instance:               4 3 2 1 0
    localparam bit [4:0] CFG_RR  = 5'b11101;
    localparam bit [4:0] CFG_BLK = 5'b01100;
    localparam bit [4:0] CFG_ACK = 5'b10111;
    localparam bit [4:0] CFG_LSB = 5'b01101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] request = '0;
    logic [3:0] acknowledge = '0;
    logic [3:0] g_o [N];
    logic       v_o [N];
    logic [1:0] e_o [N];

    int checks = 0;
    int failures = 0;
    int mg [N];
    int ml [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : u
        rr_prio_arbiter #(
            .PORTS(4),
            .ARB_TYPE_ROUND_ROBIN(CFG_RR[g]),
            .ARB_BLOCK(CFG_BLK[g]),
            .ARB_BLOCK_ACK(CFG_ACK[g]),
            .ARB_LSB_HIGH_PRIORITY(CFG_LSB[g])
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .request(request),
            .acknowledge(acknowledge),
            .grant(g_o[g]),
            .grant_valid(v_o[g]),
            .grant_encoded(e_o[g])
        );
    end

    // Reference: the granted port index (-1 = none) and the last round-robin winner.
    // Round robin is a circular search starting just past the last winner.
    task automatic model_init();
        for (int i = 0; i < N; i++) begin
            mg[i] = -1;
            ml[i] = CFG_LSB[i] ? 3 : 0;
        end
    endtask

    task automatic model_step(input int i, input logic [3:0] req, input logic [3:0] ack);
        int w;
        int p;
        w = -1;
        if (CFG_BLK[i] && !CFG_ACK[i] && mg[i] >= 0 && req[mg[i]]) return;
        if (CFG_BLK[i] && CFG_ACK[i] && mg[i] >= 0 && !ack[mg[i]]) return;
        if (req == 4'b0) begin
            mg[i] = -1;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (CFG_RR[i]) p = CFG_LSB[i] ? (ml[i] + 1 + k) % 4 : (ml[i] + 7 - k) % 4;
            else p = CFG_LSB[i] ? k : 3 - k;
            if (w < 0 && req[p]) w = p;
        end
        if (CFG_RR[i]) ml[i] = w;
        mg[i] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        request = '0;
        acknowledge = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (g_o[i] !== 4'b0 || v_o[i] !== 1'b0 || e_o[i] !== 2'd0) begin
                failures++;
                $display("FAIL reset inst=%0d grant=%b valid=%b enc=%0d want 0000/0/0", i, g_o[i], v_o[i], e_o[i]);
            end
        end
    endtask

    task automatic test_rr_rotate();
        logic [3:0] exp [5];
        exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (g_o[0] !== exp[k]) begin
                failures++;
                $display("FAIL rr_rotate step=%0d grant=%b want %b", k, g_o[0], exp[k]);
            end
        end
    endtask

    task automatic test_fixed();
        do_reset();
        request = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (g_o[1] !== 4'b0100 || e_o[1] !== 2'd2 || v_o[1] !== 1'b1) begin
                failures++;
                $display("FAIL fixed step=%0d grant=%b enc=%0d valid=%b want 0100/2/1", k, g_o[1], e_o[1], v_o[1]);
            end
        end
        request = 4'b0000;
        @(negedge clk);
        checks++;
        if (v_o[1] !== 1'b0 || g_o[1] !== 4'b0) begin
            failures++;
            $display("FAIL fixed_idle grant=%b valid=%b want 0000/0", g_o[1], v_o[1]);
        end
    endtask

    task automatic test_block_ack();
        do_reset();
        request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (g_o[2] !== 4'b0001) begin
                failures++;
                $display("FAIL block_ack_hold step=%0d grant=%b want 0001", k, g_o[2]);
            end
        end
        acknowledge = 4'b0001;
        @(negedge clk);
        acknowledge = 4'b0100;
        checks++;
        if (g_o[2] !== 4'b0010 || e_o[2] !== 2'd1) begin
            failures++;
            $display("FAIL block_ack_release grant=%b enc=%0d want 0010/1", g_o[2], e_o[2]);
        end
        @(negedge clk);
        acknowledge = 4'b0000;
        checks++;
        if (g_o[2] !== 4'b0010) begin
            failures++;
            $display("FAIL block_ack_foreign grant=%b want 0010", g_o[2]);
        end
    endtask

    task automatic test_block_req();
        do_reset();
        request = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (g_o[3] !== 4'b0001) begin
                failures++;
                $display("FAIL block_req_hold step=%0d grant=%b want 0001", k, g_o[3]);
            end
        end
        request = 4'b0010;
        @(negedge clk);
        checks++;
        if (g_o[3] !== 4'b0010) begin
            failures++;
            $display("FAIL block_req_release grant=%b want 0010", g_o[3]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        request = 4'b0101;
        @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (g_o[1] !== 4'b0100) begin
            failures++;
            $display("FAIL reset_mid_pre grant=%b want 0100", g_o[1]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (g_o[i] !== 4'b0 || v_o[i] !== 1'b0 || e_o[i] !== 2'd0) begin
                failures++;
                $display("FAIL reset_mid inst=%0d grant=%b valid=%b enc=%0d want 0000/0/0", i, g_o[i], v_o[i], e_o[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        request = 4'b1111;
        @(negedge clk);
        checks++;
        if (g_o[0] !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid_mask grant=%b want 0001", g_o[0]);
        end
    endtask

    task automatic test_pulse();
        do_reset();
        request = 4'b0010;
        #1;
        checks++;
        if (g_o[0] !== 4'b0) begin
            failures++;
            $display("FAIL pulse_early grant=%b want 0000", g_o[0]);
        end
        @(negedge clk);
        request = 4'b0000;
        checks++;
        if (g_o[0] !== 4'b0010 || e_o[0] !== 2'd1) begin
            failures++;
            $display("FAIL pulse_grant grant=%b enc=%0d want 0010/1", g_o[0], e_o[0]);
        end
        @(negedge clk);
        checks++;
        if (g_o[0] !== 4'b0 || v_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL pulse_end grant=%b valid=%b want 0000/0", g_o[0], v_o[0]);
        end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        do_reset();
        model_init();
        for (int c = 0; c < 400; c++) begin
            request = 4'($urandom);
            acknowledge = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            for (int i = 0; i < N; i++) model_step(i, request, acknowledge);
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                eg = mg[i] < 0 ? 4'b0 : 4'(1 << mg[i]);
                checks++;
                if (g_o[i] !== eg || v_o[i] !== (mg[i] >= 0) || e_o[i] !== (mg[i] < 0 ? 2'd0 : 2'(mg[i]))) begin
                    failures++;
                    $display("FAIL random cyc=%0d inst=%0d grant=%b valid=%b enc=%0d want grant=%b idx=%0d",
                             c, i, g_o[i], v_o[i], e_o[i], eg, mg[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_rotate();
        test_fixed();
        test_block_ack();
        test_block_req();
        test_reset_mid();
        test_pulse();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
